// File: rtl/fp_pkg.sv
// Shared single-precision constants and the int->fp converter state type.
// Imported by int2fp_encoder and fp_round_rne; later FPU datapaths reuse it.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } int2fp_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a 24-bit significand.
// Ports:
//   sig_i      24-bit significand, hidden bit in [23]
//   guard_i / round_i / sticky_i   bits below the mantissa lsb
//   exp_i      biased exponent of sig_i
//   mant_o     rounded 23-bit mantissa field
//   exp_o      exponent after any rounding carry
//   inexact_o  any discarded bit was set
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP_MANT_W:0]   sig_i,
  input  logic                 guard_i,
  input  logic                 round_i,
  input  logic                 sticky_i,
  input  logic [FP_EXP_W-1:0]  exp_i,
  output logic [FP_MANT_W-1:0] mant_o,
  output logic [FP_EXP_W-1:0]  exp_o,
  output logic                 inexact_o
);

  logic               inc;
  logic               exp_inc;
  logic [FP_MANT_W+1:0] sum;

  // Ties go to even: round up on a tie only when the lsb is odd.
  assign inc = guard_i & (round_i | sticky_i | sig_i[0]);
  assign sum = {1'b0, sig_i} + {{(FP_MANT_W+1){1'b0}}, inc};

  // Exponent bumps when the significand overflows 24 bits, or when a
  // subnormal (hidden bit clear) rounds up into the normal range.
  assign exp_inc   = sum[FP_MANT_W+1] | (~sig_i[FP_MANT_W] & sum[FP_MANT_W]);
  assign mant_o    = sum[FP_MANT_W-1:0];
  assign exp_o     = exp_i + {{(FP_EXP_W-1){1'b0}}, exp_inc};
  assign inexact_o = guard_i | round_i | sticky_i;

endmodule

// File: rtl/int2fp_encoder.sv
// Multi-cycle 32-bit integer to IEEE 754 single converter.
// Normalises one bit per cycle, rounds to nearest even.
// Parameter SIGNED_IN: 1 = two's complement input, 0 = unsigned.
// Ports:
//   i_w_clk, i_w_rst_n   clock, async active-low reset
//   i_w_int, i_w_valid   operand and its valid
//   o_w_ready            idle and able to accept an operand
//   o_w_out, o_w_valid   result and its valid (held until i_w_ready)
//   i_w_ready            downstream accepts result
//   o_w_inexact          only when INT2FP_INEXACT_EN is defined
module int2fp_encoder
  import fp_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        i_w_clk,
  input  logic        i_w_rst_n,
  input  logic [31:0] i_w_int,
  input  logic        i_w_valid,
  output logic        o_w_ready,
  output logic [31:0] o_w_out,
  output logic        o_w_valid,
`ifdef INT2FP_INEXACT_EN
  output logic        o_w_inexact,
`endif
  input  logic        i_w_ready
);

  int2fp_state_t        state_q, state_d;
  logic [31:0]          mag_q, mag_d;
  logic [FP_EXP_W-1:0]  exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [31:0]          out_q, out_d;
  logic [FP_MANT_W-1:0] rnd_mant;
  logic [FP_EXP_W-1:0]  rnd_exp;
`ifdef INT2FP_INEXACT_EN
  logic                 rnd_inx;
  logic                 inx_q, inx_d;
`endif

  fp_round_rne u_rnd (
    .sig_i     (mag_q[31:8]),
    .guard_i   (mag_q[7]),
    .round_i   (mag_q[6]),
    .sticky_i  (|mag_q[5:0]),
    .exp_i     (exp_q),
    .mant_o    (rnd_mant),
    .exp_o     (rnd_exp),
`ifdef INT2FP_INEXACT_EN
    .inexact_o (rnd_inx)
`else
    .inexact_o ()
`endif
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    out_d   = out_q;
`ifdef INT2FP_INEXACT_EN
    inx_d   = inx_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // The raw operand parks in mag until ABS resolves its sign.
        if (i_w_valid) begin
          mag_d   = i_w_int;
          state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        sign_d  = SIGNED_IN ? mag_q[31] : 1'b0;
        // 0x80000000 negates to itself, which is the right magnitude.
        mag_d   = sign_d ? (32'd0 - mag_q) : mag_q;
        exp_d   = FP_EXP_W'(FP_BIAS + 31);
        state_d = ST_NORM;
      end
      ST_NORM: begin
        // Zero leaves from here as +0 (sign dropped) so it never reaches
        // the rounder with a meaningless exponent.
        if (mag_q == 32'd0) begin
          out_d   = FP_POS_ZERO;
`ifdef INT2FP_INEXACT_EN
          inx_d   = 1'b0;
`endif
          state_d = ST_DONE;
        end else if (mag_q[31]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ST_ROUND: begin
        out_d   = {sign_q, rnd_exp, rnd_mant};
`ifdef INT2FP_INEXACT_EN
        inx_d   = rnd_inx;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_w_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= FP_POS_ZERO;
`ifdef INT2FP_INEXACT_EN
      inx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
`ifdef INT2FP_INEXACT_EN
      inx_q   <= inx_d;
`endif
    end
  end

  assign o_w_ready = (state_q == ST_IDLE);
  assign o_w_valid = (state_q == ST_DONE);
  assign o_w_out   = out_q;
`ifdef INT2FP_INEXACT_EN
  assign o_w_inexact = inx_q;
`endif

endmodule

// File: tb/tb_int2fp_encoder.sv
// Directed bench for int2fp_encoder: one signed and one unsigned instance
// share the clock, operand bus and downstream ready; sel picks which one
// is driven and observed.
module tb_int2fp_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        vld;
  logic        dn_rdy;
  logic [31:0] din;

  logic        vld_s, vld_u;
  logic        rdy_s, rdy_u, ov_s, ov_u;
  logic [31:0] out_s, out_u;
`ifdef INT2FP_INEXACT_EN
  logic        inx_s, inx_u;
`endif

  logic        cur_rdy, cur_val;
  logic [31:0] cur_out;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  always #5 clk = ~clk;

  assign vld_s   = vld & ~sel;
  assign vld_u   = vld & sel;
  assign cur_rdy = sel ? rdy_u : rdy_s;
  assign cur_val = sel ? ov_u  : ov_s;
  assign cur_out = sel ? out_u : out_s;

  int2fp_encoder #(.SIGNED_IN(1'b1)) u_s (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_int(din), .i_w_valid(vld_s),
    .o_w_ready(rdy_s), .o_w_out(out_s), .o_w_valid(ov_s),
`ifdef INT2FP_INEXACT_EN
    .o_w_inexact(inx_s),
`endif
    .i_w_ready(dn_rdy)
  );

  int2fp_encoder #(.SIGNED_IN(1'b0)) u_u (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_int(din), .i_w_valid(vld_u),
    .o_w_ready(rdy_u), .o_w_out(out_u), .o_w_valid(ov_u),
`ifdef INT2FP_INEXACT_EN
    .o_w_inexact(inx_u),
`endif
    .i_w_ready(dn_rdy)
  );

  // Counts operand acceptances on the observed instance.
  always @(posedge clk) if (cur_rdy && (sel ? vld_u : vld_s)) acc_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cur_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cur_rdy) chk({nm, "_ready_timeout"}, 32'(cur_rdy), 32'd1);
  endtask

  // Waits for o_w_valid, sampling 1 time unit after each edge; returns the
  // number of edges since acceptance (0 on timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (cur_val) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input logic usel, input logic [31:0] a, input logic [31:0] eo,
                         input int elat, input logic einx, input string nm);
    int lat;
    sel = usel;
    wait_ready(nm);
    din = a;
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    wait_valid(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_out"}, cur_out, eo);
`ifdef INT2FP_INEXACT_EN
    chk({nm, "_inx"}, 32'(sel ? inx_u : inx_s), 32'(einx));
`else
    if (einx === 1'bx) chk({nm, "_inx_x"}, 32'(einx), 32'd0);
`endif
  endtask

  typedef struct {
    logic        usel;
    logic [31:0] in;
    logic [31:0] out;
    int          lat;
    logic        inx;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, acc0, seen;
    logic [31:0] held;

    vecs[0]  = '{1'b0, 32'h0000_0001, 32'h3F80_0000, 34, 1'b0, "one"};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 34, 1'b0, "neg_one"};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000,  2, 1'b0, "zero_s"};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0000,  2, 1'b0, "zero_u"};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'hCF00_0000,  3, 1'b0, "int_min"};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'h4F00_0000,  3, 1'b0, "u_2p31"};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 32'h4F80_0000,  3, 1'b1, "u_max_carry"};
    vecs[7]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000, 10, 1'b1, "tie_even"};
    vecs[8]  = '{1'b0, 32'h0100_0003, 32'h4B80_0002, 10, 1'b1, "tie_up"};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF, 32'h4F00_0000,  4, 1'b1, "carry_out"};
    vecs[10] = '{1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 11, 1'b0, "exact24"};
    vecs[11] = '{1'b1, 32'h0000_03E8, 32'h447A_0000, 25, 1'b0, "u_1000"};

    sel = 1'b0; vld = 1'b0; dn_rdy = 1'b1; din = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready_s", 32'(rdy_s), 32'd1);
    chk("rst_valid_s", 32'(ov_s), 32'd0);
    chk("rst_out_s", out_s, 32'h0);
    chk("rst_ready_u", 32'(rdy_u), 32'd1);
    chk("rst_valid_u", 32'(ov_u), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_vec(vecs[i].usel, vecs[i].in, vecs[i].out, vecs[i].lat, vecs[i].inx, vecs[i].nm);

    // Reset in the middle of normalisation aborts with no result.
    sel = 1'b0;
    wait_ready("rst_mid");
    din = 32'd1;
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(ov_s), 32'd0);
    chk("rst_mid_ready", 32'(rdy_s), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ov_s) seen++;
    end
    chk("rst_mid_no_result", 32'(seen), 32'd0);

    // Backpressure: result held, busy, second operand ignored.
    sel = 1'b0;
    dn_rdy = 1'b0;
    wait_ready("bp");
    acc0 = acc_cnt;
    din = 32'd5;
    vld = 1'b1;
    @(posedge clk);
    #1 din = 32'd7;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd32);
    held = 32'h40A0_0000;
    chk("bp_out", out_s, held);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(ov_s), 32'd1);
      chk("bp_hold_out", out_s, held);
      chk("bp_hold_ready", 32'(rdy_s), 32'd0);
    end
    chk("bp_single_accept", 32'(acc_cnt - acc0), 32'd1);
    @(negedge clk);
    vld = 1'b0;
    dn_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(ov_s), 32'd0);
    chk("bp_release_ready", 32'(rdy_s), 32'd1);
    run_vec(1'b0, 32'd1000, 32'h447A_0000, 25, 1'b0, "bp_next");

    // Back-to-back with i_w_valid held high throughout.
    sel = 1'b0;
    wait_ready("b2b");
    acc0 = acc_cnt;
    din = 32'd5;
    vld = 1'b1;
    wait_valid(lat);
    chk("b2b_5", out_s, 32'h40A0_0000);
    chk("b2b_busy", 32'(rdy_s), 32'd0);
    @(negedge clk) din = 32'hFFFF_FFFB;
    wait_valid(lat);
    chk("b2b_m5", out_s, 32'hC0A0_0000);
    @(negedge clk) din = 32'd1000;
    wait_valid(lat);
    chk("b2b_1000", out_s, 32'h447A_0000);
    @(negedge clk) vld = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
